boot_ctrl: RTL and testbench



---
 rtl/boot_ctrl_pkg.sv | 22 ++
 rtl/boot_ctrl_run_monitor.sv | 58 +++++
 rtl/boot_ctrl.sv | 131 +++++++++++++
 tb/tb_boot_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/boot_ctrl_pkg.sv
// Shared definitions for the boot/run controller: memory write codes and
// controller state encodings.
package boot_ctrl_pkg;

  typedef enum logic [1:0] {
    WR_NONE = 2'b00,
    WR_BYTE = 2'b01,
    WR_HALF = 2'b10,
    WR_WORD = 2'b11
  } wr_code_e;

  typedef enum logic [2:0] {
    BC_IDLE    = 3'd0,
    BC_LOAD    = 3'd1,
    BC_RELEASE = 3'd2,
    BC_RUN     = 3'd3,
    BC_HALT    = 3'd4
  } bc_state_e;

  localparam int CYCLES_W = 32;

endpackage

// File: rtl/boot_ctrl_run_monitor.sv
// Run monitor: snoops CPU stores for the tohost address, counts run cycles,
// detects timeout and holds the result flags until the next load.
module run_monitor
  import boot_ctrl_pkg::*;
#(
  parameter int                   ADDR_W      = 32,
  parameter int                   DATA_W      = 32,
  parameter logic [ADDR_W-1:0]    TOHOST_ADDR = ADDR_W'(32'h0000_1000),
  parameter longint unsigned      TIMEOUT     = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                run,
  input  logic                load_err_set,
  input  logic [1:0]          cpu_wr,
  input  logic [ADDR_W-1:0]   cpu_waddr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic                tohost_hit,
  output logic                timeout_hit,
  output logic                pass,
  output logic                timeout_err,
  output logic                load_err,
  output logic [DATA_W-1:0]   exit_code,
  output logic [CYCLES_W-1:0] cycles
);

  // Compared at 64 bits so a TIMEOUT beyond the counter range never matches
  // and the counter simply saturates.
  localparam logic [63:0] TIMEOUT_LAST = 64'(TIMEOUT) - 64'd1;

  assign tohost_hit  = run && (cpu_wr != WR_NONE) && (cpu_waddr == TOHOST_ADDR);
  assign timeout_hit = run && !tohost_hit && ({32'd0, cycles} == TIMEOUT_LAST);

  // NOTE: reset is synchronous, so it lives inside the clocked block; state is
  // updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pass        <= 1'b0;
      timeout_err <= 1'b0;
      load_err    <= 1'b0;
      exit_code   <= '0;
      cycles      <= '0;
    end else begin
      if (load_err_set) load_err <= 1'b1;
      // The terminating edge does not count, so CYCLES shows the last run cycle.
      if (tohost_hit) begin
        exit_code <= cpu_wdata;
        pass      <= (cpu_wdata == DATA_W'(1));
      end else if (timeout_hit) begin
        timeout_err <= 1'b1;
      end else if (run && (cycles != '1)) begin
        cycles <= cycles + 1'b1;
      end
    end
  end

endmodule

// File: rtl/boot_ctrl.sv
// Program-load and run controller: streams an image into main memory with the
// core held in reset, then releases the core and stops on tohost or timeout.
module boot_ctrl
  import boot_ctrl_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(32'h0000_1000),
  parameter longint unsigned   TIMEOUT     = 100000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic                LD_VALID,
  input  logic [DATA_W-1:0]   LD_DATA,
  input  logic                LD_LAST,
  output logic                LD_READY,
  output logic [1:0]          MEM_WR,
  output logic [ADDR_W-1:0]   MEM_ADDR,
  output logic [DATA_W-1:0]   MEM_DATA,
  input  logic [1:0]          CPU_WR,
  input  logic [ADDR_W-1:0]   CPU_WADDR,
  input  logic [DATA_W-1:0]   CPU_WDATA,
  output logic                CPU_RST,
  output logic                DONE,
  output logic                PASS,
  output logic                TIMEOUT_ERR,
  output logic                LOAD_ERR,
  output logic [DATA_W-1:0]   EXIT_CODE,
  output logic [CYCLES_W-1:0] CYCLES
);

  bc_state_e         state, state_next;
  logic [31:0]       idx, idx_next;
  logic [1:0]        mem_wr_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [DATA_W-1:0] mem_data_next;
  logic              clear, load_err_set;
  logic              tohost_hit, timeout_hit;

  run_monitor #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TOHOST_ADDR (TOHOST_ADDR),
    .TIMEOUT     (TIMEOUT)
  ) u_run_monitor (
    .clk          (CLK),
    .rst          (RST),
    .clear        (clear),
    .run          (state == BC_RUN),
    .load_err_set (load_err_set),
    .cpu_wr       (CPU_WR),
    .cpu_waddr    (CPU_WADDR),
    .cpu_wdata    (CPU_WDATA),
    .tohost_hit   (tohost_hit),
    .timeout_hit  (timeout_hit),
    .pass         (PASS),
    .timeout_err  (TIMEOUT_ERR),
    .load_err     (LOAD_ERR),
    .exit_code    (EXIT_CODE),
    .cycles       (CYCLES)
  );

  assign LD_READY = (state == BC_LOAD);
  assign DONE     = (state == BC_HALT);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    mem_wr_next   = WR_NONE;
    mem_addr_next = MEM_ADDR;
    mem_data_next = MEM_DATA;
    clear         = 1'b0;
    load_err_set  = 1'b0;
    case (state)
      BC_IDLE, BC_HALT: begin
        if (START) begin
          state_next = BC_LOAD;
          idx_next   = '0;
          clear      = 1'b1;
        end
      end
      BC_LOAD: begin
        if (LD_VALID) begin
          mem_wr_next   = WR_WORD;
          mem_addr_next = BASE_ADDR + ADDR_W'({idx, 2'b00});
          mem_data_next = LD_DATA;
          idx_next      = idx + 32'd1;
          if (LD_LAST) begin
            state_next = BC_RELEASE;
          end else if (idx == 32'(DEPTH - 1)) begin
            load_err_set = 1'b1;
            state_next   = BC_HALT;
          end
        end
      end
      BC_RELEASE: state_next = BC_RUN;
      BC_RUN: begin
        mem_wr_next   = CPU_WR;
        mem_addr_next = CPU_WADDR;
        mem_data_next = CPU_WDATA;
        if (tohost_hit || timeout_hit) state_next = BC_HALT;
      end
      default: state_next = BC_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= BC_IDLE;
      idx      <= '0;
      MEM_WR   <= WR_NONE;
      MEM_ADDR <= '0;
      MEM_DATA <= '0;
      CPU_RST  <= 1'b1;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      MEM_WR   <= mem_wr_next;
      MEM_ADDR <= mem_addr_next;
      MEM_DATA <= mem_data_next;
      // Registered from the next state so the core is held the cycle HALT begins.
      CPU_RST  <= (state_next != BC_RUN);
    end
  end

endmodule

// File: tb/tb_boot_ctrl.sv
// Directed bench for boot_ctrl: memory writes are checked against a queue of
// expected writes; flags and counters are checked at each step.
module tb_boot_ctrl;

  localparam int          TB_DEPTH   = 4;
  localparam int          TB_TIMEOUT = 20;
  localparam logic [31:0] TB_BASE    = 32'h0000_0000;
  localparam logic [31:0] TB_TOHOST  = 32'h0000_1000;

  typedef struct packed {
    logic [1:0]  wr;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        CLK = 1'b0;
  logic        RST, START, LD_VALID, LD_LAST, LD_READY;
  logic [31:0] LD_DATA;
  logic [1:0]  MEM_WR, CPU_WR;
  logic [31:0] MEM_ADDR, MEM_DATA, CPU_WADDR, CPU_WDATA;
  logic        CPU_RST, DONE, PASS, TIMEOUT_ERR, LOAD_ERR;
  logic [31:0] EXIT_CODE, CYCLES;

  int  checks   = 0;
  int  failures = 0;
  int  load_idx = 0;
  wr_t exp_q[$];

  boot_ctrl #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(TB_DEPTH), .BASE_ADDR(TB_BASE),
    .TOHOST_ADDR(TB_TOHOST), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .LD_VALID(LD_VALID), .LD_DATA(LD_DATA), .LD_LAST(LD_LAST), .LD_READY(LD_READY),
    .MEM_WR(MEM_WR), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
    .CPU_WR(CPU_WR), .CPU_WADDR(CPU_WADDR), .CPU_WDATA(CPU_WDATA),
    .CPU_RST(CPU_RST), .DONE(DONE), .PASS(PASS), .TIMEOUT_ERR(TIMEOUT_ERR),
    .LOAD_ERR(LOAD_ERR), .EXIT_CODE(EXIT_CODE), .CYCLES(CYCLES)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Memory write port monitor: every write must match the oldest expectation.
  always @(negedge CLK) begin
    if (!RST && MEM_WR != 2'b00) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_write", 96'(MEM_WR), 96'(2'b00));
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("sb_mem_write", 96'({MEM_WR, MEM_ADDR, MEM_DATA}), 96'(e));
      end
    end
  end

  task automatic send_beat(input logic [31:0] data, input logic last, input bit gap);
    int waited = 0;
    LD_VALID = 1'b1;
    LD_DATA  = data;
    LD_LAST  = last;
    while (!LD_READY && waited < 8) begin
      tick();
      waited++;
    end
    if (!LD_READY) begin
      check("ld_ready_wait", 96'(LD_READY), 96'(1));
    end else begin
      exp_q.push_back('{2'b11, TB_BASE + 32'(4 * load_idx), data});
      load_idx++;
      tick();
    end
    LD_VALID = 1'b0;
    LD_LAST  = 1'b0;
    LD_DATA  = $urandom;
    if (gap) tick();
  endtask

  task automatic start_pulse();
    START = 1'b1;
    tick();
    START = 1'b0;
    load_idx = 0;
  endtask

  task automatic cpu_store(input logic [31:0] addr, input logic [31:0] data);
    CPU_WR    = 2'b11;
    CPU_WADDR = addr;
    CPU_WDATA = data;
    exp_q.push_back('{2'b11, addr, data});
    tick();
    CPU_WR    = 2'b00;
    CPU_WADDR = $urandom;
    CPU_WDATA = $urandom;
  endtask

  initial begin
    int n;
    RST = 1'b1; START = 1'b0; LD_VALID = 1'b0; LD_LAST = 1'b0; LD_DATA = '0;
    CPU_WR = 2'b00; CPU_WADDR = '0; CPU_WDATA = '0;
    tick(); tick();
    RST = 1'b0;

    // Reset state
    check("rst_cpu_rst", 96'(CPU_RST), 96'(1));
    check("rst_ld_ready", 96'(LD_READY), 96'(0));
    check("rst_mem", 96'({MEM_WR, MEM_ADDR, MEM_DATA}), 96'(0));
    check("rst_flags", 96'({DONE, PASS, TIMEOUT_ERR, LOAD_ERR}), 96'(0));
    check("rst_exit_cycles", 96'({EXIT_CODE, CYCLES}), 96'(0));

    // Three-word load, then pass-through store and tohost=1 on run cycle 5
    start_pulse();
    check("load_ready", 96'(LD_READY), 96'(1));
    send_beat(32'h0050_01B7, 1'b0, 1'b0);
    send_beat(32'h0010_0093, 1'b0, 1'b0);
    send_beat(32'h0010_2023, 1'b1, 1'b0);
    check("release_cpu_rst", 96'(CPU_RST), 96'(1));
    check("release_ld_ready", 96'(LD_READY), 96'(0));
    tick();
    check("run0_cpu_rst", 96'(CPU_RST), 96'(0));
    check("run0_cycles", 96'(CYCLES), 96'(0));
    tick(); tick();
    cpu_store(32'h0000_0020, 32'h0000_00AB);
    check("plain_store_not_done", 96'(DONE), 96'(0));
    tick(); tick();
    check("run5_cycles", 96'(CYCLES), 96'(5));
    cpu_store(TB_TOHOST, 32'd1);
    check("pass_done_cpu_rst", 96'({DONE, CPU_RST}), 96'(2'b11));
    check("pass_flags", 96'({PASS, TIMEOUT_ERR, LOAD_ERR}), 96'(3'b100));
    check("pass_exit_cycles", 96'({EXIT_CODE, CYCLES}), 96'({32'd1, 32'd5}));
    tick(); tick();
    check("halt_frozen", 96'({DONE, PASS, CYCLES}), 96'({2'b11, 32'd5}));

    // START from HALT clears everything; then tohost=7
    start_pulse();
    check("clear_flags", 96'({DONE, PASS, TIMEOUT_ERR, LOAD_ERR}), 96'(0));
    check("clear_exit_cycles", 96'({EXIT_CODE, CYCLES}), 96'(0));
    send_beat(32'hDEAD_BEEF, 1'b1, 1'b0);
    tick(); tick(); tick();
    cpu_store(TB_TOHOST, 32'h7);
    check("fail_code", 96'({DONE, PASS, EXIT_CODE, CYCLES}), 96'({2'b10, 32'h7, 32'd2}));

    // Timeout with no store; START during RUN is ignored
    start_pulse();
    send_beat(32'h0000_0013, 1'b1, 1'b0);
    tick(); tick(); tick();
    start_pulse();
    check("start_ignored_in_run", 96'({CPU_RST, DONE}), 96'(0));
    n = 0;
    while (!DONE && n < 40) begin
      tick();
      n++;
    end
    check("timeout_done", 96'(DONE), 96'(1));
    check("timeout_flags", 96'({TIMEOUT_ERR, PASS, CPU_RST}), 96'(3'b101));
    check("timeout_cycles", 96'(CYCLES), 96'(TB_TIMEOUT - 1));

    // Tohost store on the last allowed cycle beats the timeout
    start_pulse();
    send_beat(32'h0000_0013, 1'b1, 1'b0);
    tick();
    repeat (TB_TIMEOUT - 1) tick();
    check("last_cycle_count", 96'({DONE, CYCLES}), 96'({1'b0, 32'(TB_TIMEOUT - 1)}));
    cpu_store(TB_TOHOST, 32'd1);
    check("tohost_wins", 96'({DONE, PASS, TIMEOUT_ERR}), 96'(3'b110));
    check("tohost_wins_cycles", 96'(CYCLES), 96'(TB_TIMEOUT - 1));

    // Image longer than DEPTH: only DEPTH words written, core never released
    start_pulse();
    for (int i = 0; i < TB_DEPTH; i++) send_beat(32'hA000_0000 + 32'(i), 1'b0, 1'b0);
    check("overflow_flags", 96'({LOAD_ERR, DONE, CPU_RST, LD_READY}), 96'(4'b1110));
    LD_VALID = 1'b1;
    LD_DATA  = 32'hA000_0004;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("overflow_cpu_held", 96'({CPU_RST, LOAD_ERR}), 96'(2'b11));
    end
    LD_VALID = 1'b0;

    // Gapped beats give contiguous addresses; reset mid-run aborts to IDLE
    start_pulse();
    check("restart_clears_load_err", 96'(LOAD_ERR), 96'(0));
    send_beat(32'h1111_1111, 1'b0, 1'b1);
    send_beat(32'h2222_2222, 1'b0, 1'b1);
    send_beat(32'h3333_3333, 1'b1, 1'b0);
    tick();
    repeat (10) tick();
    check("pre_reset_run", 96'({CPU_RST, CYCLES}), 96'({1'b0, 32'd10}));
    RST = 1'b1;
    tick();
    check("midrun_reset", 96'({CPU_RST, DONE, LD_READY, CYCLES}), 96'({3'b100, 32'd0}));
    RST = 1'b0;
    tick();
    check("after_reset_idle", 96'({CPU_RST, LD_READY, MEM_WR}), 96'(4'b1000));

    check("sb_all_writes_seen", 96'(exp_q.size()), 96'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
